// File: rtl/pc_fetch_ctrl.sv
// Program counter and instruction-fetch sequencer for the single-cycle RV32 core.
// Runs one request/grant/response fetch at a time and holds the result until the core retires it.
module pc_fetch_ctrl #(
  parameter logic [31:0] RESET_PC     = 32'h0000_0000,
  parameter logic [31:0] TRAP_PC      = 32'h0000_0100,
  parameter int unsigned TIMEOUT      = 16,
  // Value instret takes on reset, e.g. to resume a saved count; normally zero.
  parameter logic [31:0] INSTRET_INIT = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] next_pc,
  input  logic        instr_accept,
  input  logic        fault_clear,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] pc_out,
  output logic [31:0] instr_out,
  output logic        instr_valid,
  output logic        fault,
  output logic [1:0]  fault_cause,
  output logic [31:0] fault_addr,
  output logic [31:0] instret
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_REQ   = 3'd1;
  localparam logic [2:0] S_WAIT  = 3'd2;
  localparam logic [2:0] S_VALID = 3'd3;
  localparam logic [2:0] S_FAULT = 3'd4;

  localparam logic [7:0] LP_CNT_MAX = 8'(TIMEOUT - 1);

  logic [2:0]  r_state;
  logic [31:0] r_pc;
  logic [31:0] r_instr;
  logic        r_instr_valid;
  logic        r_fault;
  logic [1:0]  r_fault_cause;
  logic [31:0] r_fault_addr;
  logic [31:0] r_instret;
  logic [7:0]  r_cnt;
  logic        w_aligned;

  assign w_aligned = (next_pc[1:0] == 2'b00);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= S_IDLE;
      r_pc          <= RESET_PC;
      r_instr       <= 32'h0;
      r_instr_valid <= 1'b0;
      r_fault       <= 1'b0;
      r_fault_cause <= 2'b00;
      r_fault_addr  <= 32'h0;
      r_instret     <= INSTRET_INIT;
      r_cnt         <= 8'h0;
    end else begin
      case (r_state)
        S_IDLE: r_state <= S_REQ;
        S_REQ: begin
          if (imem_gnt && imem_rvalid) begin
            r_instr       <= imem_rdata;
            r_instr_valid <= 1'b1;
            r_state       <= S_VALID;
          end else if (imem_gnt) begin
            r_cnt   <= 8'h0;
            r_state <= S_WAIT;
          end
        end
        S_WAIT: begin
          // A response arriving in the final counted cycle still wins over the timeout.
          if (imem_rvalid) begin
            r_instr       <= imem_rdata;
            r_instr_valid <= 1'b1;
            r_state       <= S_VALID;
          end else if (r_cnt == LP_CNT_MAX) begin
            r_fault       <= 1'b1;
            r_fault_cause <= 2'b10;
            r_fault_addr  <= r_pc;
            r_state       <= S_FAULT;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        S_VALID: begin
          if (instr_accept) begin
            r_instret     <= r_instret + 32'd1;
            r_instr_valid <= 1'b0;
            if (w_aligned) begin
              r_pc    <= next_pc;
              r_state <= S_REQ;
            end else begin
              r_fault       <= 1'b1;
              r_fault_cause <= 2'b01;
              r_fault_addr  <= next_pc;
              r_state       <= S_FAULT;
            end
          end
        end
        S_FAULT: begin
          if (fault_clear) begin
            r_pc          <= TRAP_PC;
            r_fault       <= 1'b0;
            r_fault_cause <= 2'b00;
            r_state       <= S_REQ;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign imem_req    = (r_state == S_REQ);
  assign imem_addr   = r_pc;
  assign pc_out      = r_pc;
  assign instr_out   = r_instr;
  assign instr_valid = r_instr_valid;
  assign fault       = r_fault;
  assign fault_cause = r_fault_cause;
  assign fault_addr  = r_fault_addr;
  assign instret     = r_instret;

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Directed bench for pc_fetch_ctrl; a second instance starts instret at all-ones to exercise wrap.
module tb_pc_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] next_pc;
  logic        instr_accept;
  logic        fault_clear;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;

  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] pc_out;
  logic [31:0] instr_out;
  logic        instr_valid;
  logic        fault;
  logic [1:0]  fault_cause;
  logic [31:0] fault_addr;
  logic [31:0] instret;

  logic        w_req_w;
  logic [31:0] w_addr_w;
  logic [31:0] w_pc_w;
  logic [31:0] w_instr_w;
  logic        w_valid_w;
  logic        w_fault_w;
  logic [1:0]  w_cause_w;
  logic [31:0] w_faddr_w;
  logic [31:0] w_instret_w;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  pc_fetch_ctrl dut (
    .clk(clk), .rst_n(rst_n), .next_pc(next_pc), .instr_accept(instr_accept),
    .fault_clear(fault_clear), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_gnt(imem_gnt), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .pc_out(pc_out), .instr_out(instr_out), .instr_valid(instr_valid),
    .fault(fault), .fault_cause(fault_cause), .fault_addr(fault_addr),
    .instret(instret)
  );

  pc_fetch_ctrl #(.INSTRET_INIT(32'hFFFF_FFFF)) dut_w (
    .clk(clk), .rst_n(rst_n), .next_pc(next_pc), .instr_accept(instr_accept),
    .fault_clear(fault_clear), .imem_req(w_req_w), .imem_addr(w_addr_w),
    .imem_gnt(imem_gnt), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .pc_out(w_pc_w), .instr_out(w_instr_w), .instr_valid(w_valid_w),
    .fault(w_fault_w), .fault_cause(w_cause_w), .fault_addr(w_faddr_w),
    .instret(w_instret_w)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
      $display("ok   %-16s got=%h", tag, got);
    end else begin
      $display("FAIL %-16s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Same-cycle grant and response from REQ; leaves the DUT in VALID.
  task automatic fetch(input logic [31:0] data);
    imem_gnt    = 1'b1;
    imem_rvalid = 1'b1;
    imem_rdata  = data;
    tick();
    imem_gnt    = 1'b0;
    imem_rvalid = 1'b0;
  endtask

  task automatic accept(input logic [31:0] npc);
    instr_accept = 1'b1;
    next_pc      = npc;
    tick();
    instr_accept = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0; next_pc = 32'h0; instr_accept = 1'b0; fault_clear = 1'b0;
    imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'h0;
    tick(); tick();
    check("rst_pc", pc_out, 32'h0);
    check("rst_req", {31'h0, imem_req}, 32'h0);
    check("rst_valid", {31'h0, instr_valid}, 32'h0);
    check("rst_fault", {29'h0, fault, fault_cause}, 32'h0);
    check("rst_faddr", fault_addr, 32'h0);
    check("rst_instret", instret, 32'h0);
    check("rst_instr", instr_out, 32'h0);
    rst_n = 1'b1;

    // First fetch: grant at once, response one cycle later.
    tick();
    check("t1_req", {31'h0, imem_req}, 32'h1);
    check("t1_addr", imem_addr, 32'h0);
    imem_gnt = 1'b1;
    tick();
    imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'h0050_0093;
    check("t1_wait_req", {31'h0, imem_req}, 32'h0);
    tick();
    imem_rvalid = 1'b0;
    check("t1_instr", instr_out, 32'h0050_0093);
    check("t1_valid", {31'h0, instr_valid}, 32'h1);
    accept(32'h4);
    check("t1_pc", pc_out, 32'h4);
    check("t1_instret", instret, 32'h1);
    check("t1_valid_clr", {31'h0, instr_valid}, 32'h0);
    check("t1_req2", {31'h0, imem_req}, 32'h1);

    // Jump to an aligned target.
    fetch(32'h0400_006F);
    accept(32'h40);
    check("t2_addr", imem_addr, 32'h40);
    check("t2_fault", {31'h0, fault}, 32'h0);
    check("t2_req", {31'h0, imem_req}, 32'h1);

    // Misaligned target faults and keeps the PC; clear redirects to the trap vector.
    fetch(32'h0020_0067);
    accept(32'h42);
    check("t3_fault", {31'h0, fault}, 32'h1);
    check("t3_cause", {30'h0, fault_cause}, 32'h1);
    check("t3_faddr", fault_addr, 32'h42);
    check("t3_pc", pc_out, 32'h40);
    check("t3_instret", instret, 32'h3);
    check("t3_req", {31'h0, imem_req}, 32'h0);
    tick();
    check("t3_hold", {31'h0, fault}, 32'h1);
    fault_clear = 1'b1;
    tick();
    fault_clear = 1'b0;
    check("t3_clr_fault", {29'h0, fault, fault_cause}, 32'h0);
    check("t3_clr_pc", pc_out, 32'h100);
    check("t3_clr_addr", imem_addr, 32'h100);
    check("t3_clr_req", {31'h0, imem_req}, 32'h1);

    // Grant, then no response for 16 WAIT cycles.
    imem_gnt = 1'b1;
    tick();
    imem_gnt = 1'b0;
    for (int i = 0; i < 15; i++) tick();
    check("t4_prefault", {31'h0, fault}, 32'h0);
    tick();
    check("t4_fault", {31'h0, fault}, 32'h1);
    check("t4_cause", {30'h0, fault_cause}, 32'h2);
    check("t4_faddr", fault_addr, 32'h100);
    fault_clear = 1'b1;
    tick();
    fault_clear = 1'b0;

    // Response in the last counted cycle wins over the timeout.
    imem_gnt = 1'b1;
    tick();
    imem_gnt = 1'b0;
    for (int i = 0; i < 15; i++) tick();
    imem_rvalid = 1'b1; imem_rdata = 32'h00A0_0113;
    tick();
    imem_rvalid = 1'b0;
    check("t5_fault", {31'h0, fault}, 32'h0);
    check("t5_valid", {31'h0, instr_valid}, 32'h1);
    check("t5_instr", instr_out, 32'h00A0_0113);
    accept(32'h104);
    check("t5_addr", imem_addr, 32'h104);

    // Reset in the middle of WAIT; a late response after release is dropped.
    imem_gnt = 1'b1;
    tick();
    imem_gnt = 1'b0;
    tick(); tick();
    rst_n = 1'b0;
    #1;
    check("t6_async_pc", pc_out, 32'h0);
    check("t6_async_instr", instr_out, 32'h0);
    #2;
    rst_n = 1'b1;
    imem_rvalid = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    tick();
    imem_rvalid = 1'b0;
    check("t6_valid", {31'h0, instr_valid}, 32'h0);
    check("t6_instr", instr_out, 32'h0);
    check("t6_pc", pc_out, 32'h0);
    check("t6_instret", instret, 32'h0);
    check("t6_req", {31'h0, imem_req}, 32'h1);

    // Back-pressure: no grant for 5 cycles; stray accept and clear are ignored.
    for (int i = 0; i < 5; i++) begin
      instr_accept = (i == 2);
      fault_clear  = (i == 3);
      next_pc      = 32'h0000_0800;
      tick();
      check($sformatf("t7_req_%0d", i), {31'h0, imem_req}, 32'h1);
      check($sformatf("t7_addr_%0d", i), imem_addr, 32'h0);
    end
    instr_accept = 1'b0; fault_clear = 1'b0;
    check("t7_instret", instret, 32'h0);
    fetch(32'h0000_0013);
    check("t7_instr", instr_out, 32'h0000_0013);
    check("t7_wrap_pre", w_instret_w, 32'hFFFF_FFFF);
    accept(32'h4);
    check("t7_wrap", w_instret_w, 32'h0);
    check("t7_instret1", instret, 32'h1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
